// File: rtl/note_sequencer.sv
// note_sequencer: plays a stored 16-step melody as a one-hot note-select bus
// (bit order matches the manual switches) and, while idle, forwards the
// highest-priority manual switch onto the same bus.
module note_sequencer #(
  parameter int unsigned TICK_DIV  = 6250000,
  parameter int unsigned GAP_TICKS = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       play,
  input  logic       stop,
  input  logic       loop,
  input  logic [7:0] sw,
  output logic [7:0] note_sel,
  output logic       busy,
  output logic       done,
  output logic [3:0] step
);

  localparam int unsigned CNT_W = (TICK_DIV > 32'd1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned GAP_W = (GAP_TICKS > 32'd1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 32'd1);
  localparam logic [GAP_W-1:0] GAP_INIT =
    GAP_W'((GAP_TICKS > 32'd0) ? (GAP_TICKS - 32'd1) : 32'd0);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_NOTE = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  // Melody ROM: {code[7:4], dur[3:0]}; codes 9..15 mark the end of the song.
  function automatic logic [7:0] rom_entry(input logic [3:0] idx);
    logic [7:0] e;
    case (idx)
      4'd0:    e = 8'h11;
      4'd1:    e = 8'h11;
      4'd2:    e = 8'h51;
      4'd3:    e = 8'h51;
      4'd4:    e = 8'h61;
      4'd5:    e = 8'h61;
      4'd6:    e = 8'h53;
      4'd7:    e = 8'h41;
      4'd8:    e = 8'h41;
      4'd9:    e = 8'h31;
      4'd10:   e = 8'h31;
      4'd11:   e = 8'h21;
      4'd12:   e = 8'h21;
      4'd13:   e = 8'h13;
      default: e = 8'hF0;
    endcase
    return e;
  endfunction

  // Note code 1..8 (C4..C5) to switch-ordered one-hot; rest and markers give 0.
  function automatic logic [7:0] code_to_onehot(input logic [3:0] code);
    logic [7:0] oh;
    case (code)
      4'd1:    oh = 8'h80;
      4'd2:    oh = 8'h40;
      4'd3:    oh = 8'h20;
      4'd4:    oh = 8'h10;
      4'd5:    oh = 8'h08;
      4'd6:    oh = 8'h04;
      4'd7:    oh = 8'h02;
      4'd8:    oh = 8'h01;
      default: oh = 8'h00;
    endcase
    return oh;
  endfunction

  // Manual arbitration: the lowest note (sw[7]) wins.
  function automatic logic [7:0] sw_priority(input logic [7:0] s);
    logic [7:0] oh;
    casez (s)
      8'b1???_????: oh = 8'h80;
      8'b01??_????: oh = 8'h40;
      8'b001?_????: oh = 8'h20;
      8'b0001_????: oh = 8'h10;
      8'b0000_1???: oh = 8'h08;
      8'b0000_01??: oh = 8'h04;
      8'b0000_001?: oh = 8'h02;
      8'b0000_0001: oh = 8'h01;
      default:      oh = 8'h00;
    endcase
    return oh;
  endfunction

  state_e           state_q, state_d;
  logic [3:0]       step_q, step_d;
  logic [7:0]       note_q, note_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [3:0]       dur_q, dur_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             tick_s;
  logic [7:0]       rom_s;
  logic             timed_q_s;
  logic             timed_d_s;
  state_e           adv_state_s;
  logic [3:0]       adv_step_s;

  assign tick_s    = (cnt_q == CNT_LAST);
  assign rom_s     = rom_entry(step_q);
  assign timed_q_s = (state_q == S_NOTE) || (state_q == S_GAP);
  assign timed_d_s = (state_d == S_NOTE) || (state_d == S_GAP);

  // Where the song goes after the current step finishes.
  always_comb begin
    adv_state_s = S_LOAD;
    adv_step_s  = step_q + 4'd1;
    if (step_q == 4'd15) begin
      adv_step_s  = 4'd0;
      adv_state_s = loop ? S_LOAD : S_DONE;
    end else begin
      adv_step_s  = step_q + 4'd1;
      adv_state_s = S_LOAD;
    end
  end

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    note_d  = note_q;
    dur_d   = dur_q;
    gap_d   = gap_q;
    cnt_d   = {CNT_W{1'b0}};
    case (state_q)
      S_IDLE: begin
        note_d = sw_priority(sw);
        if (play && !stop) begin
          state_d = S_LOAD;
          step_d  = 4'd0;
          note_d  = 8'h00;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        note_d = 8'h00;
        if (stop) begin
          state_d = S_IDLE;
          step_d  = 4'd0;
        end else if (rom_s[7:4] >= 4'd9) begin
          // End marker: restart unless already at step 0 (empty song).
          if (loop && (step_q != 4'd0)) begin
            step_d  = 4'd0;
            state_d = S_LOAD;
          end else begin
            step_d  = 4'd0;
            state_d = S_DONE;
          end
        end else begin
          dur_d   = rom_s[3:0];
          note_d  = code_to_onehot(rom_s[7:4]);
          state_d = S_NOTE;
        end
      end
      S_NOTE: begin
        if (stop) begin
          state_d = S_IDLE;
          step_d  = 4'd0;
          note_d  = 8'h00;
        end else if (tick_s && (dur_q == 4'd0)) begin
          note_d = 8'h00;
          if (GAP_TICKS == 32'd0) begin
            state_d = adv_state_s;
            step_d  = adv_step_s;
          end else begin
            state_d = S_GAP;
            gap_d   = GAP_INIT;
          end
        end else if (tick_s) begin
          dur_d = dur_q - 4'd1;
        end else begin
          dur_d = dur_q;
        end
      end
      S_GAP: begin
        note_d = 8'h00;
        if (stop) begin
          state_d = S_IDLE;
          step_d  = 4'd0;
        end else if (tick_s && (gap_q == {GAP_W{1'b0}})) begin
          state_d = adv_state_s;
          step_d  = adv_step_s;
        end else if (tick_s) begin
          gap_d = gap_q - GAP_W'(1);
        end else begin
          gap_d = gap_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        step_d  = 4'd0;
        note_d  = 8'h00;
      end
      default: begin
        state_d = S_IDLE;
        step_d  = 4'd0;
        note_d  = 8'h00;
      end
    endcase

    // Tempo counter only runs while a note or gap is being timed.
    if (timed_q_s && timed_d_s && !tick_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end

    busy_d = (state_d == S_LOAD) || (state_d == S_NOTE) || (state_d == S_GAP);
    done_d = (state_d == S_DONE);
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      step_q  <= 4'd0;
      note_q  <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dur_q   <= 4'd0;
      gap_q   <= {GAP_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      note_q  <= note_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dur_q   <= dur_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
    end
  end

  assign note_sel = note_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign step     = step_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer with TICK_DIV=4, GAP_TICKS=1.
module tb_note_sequencer;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       play;
  logic       stop;
  logic       loop;
  logic [7:0] sw;
  logic [7:0] note_sel;
  logic       busy;
  logic       done;
  logic [3:0] step;

  always #5 CLK = ~CLK;

  note_sequencer #(.TICK_DIV(4), .GAP_TICKS(1)) dut (
    .CLK(CLK), .RESET(RESET), .play(play), .stop(stop), .loop(loop),
    .sw(sw), .note_sel(note_sel), .busy(busy), .done(done), .step(step)
  );

  typedef struct packed {
    logic [7:0] note;
    logic       busy;
    logic       done;
    logic [3:0] step;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_bad = 0;
  int   busy_cnt = 0;
  int   done_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Melody as written in the song sheet: C C G G A A G F F E E D D C.
  function automatic logic [7:0] mel_note(input int s);
    case (s)
      0, 1, 13: return 8'h80;
      2, 3, 6:  return 8'h08;
      4, 5:     return 8'h04;
      7, 8:     return 8'h10;
      9, 10:    return 8'h20;
      11, 12:   return 8'h40;
      default:  return 8'h00;
    endcase
  endfunction

  function automatic int mel_dur(input int s);
    return ((s == 6) || (s == 13)) ? 3 : 1;
  endfunction

  task automatic push(input logic [7:0] n, input logic b, input logic d, input logic [3:0] s);
    exp_t e;
    e.note = n;
    e.busy = b;
    e.done = d;
    e.step = s;
    exp_q.push_back(e);
  endtask

  // Expected per-cycle outputs of one song pass, starting with the first LOAD.
  task automatic push_song(input bit finish);
    for (int s = 0; s < 14; s++) begin
      push(8'h00, 1'b1, 1'b0, 4'(s));
      for (int k = 0; k < (mel_dur(s) + 1) * 4; k++) push(mel_note(s), 1'b1, 1'b0, 4'(s));
      for (int k = 0; k < 4; k++) push(8'h00, 1'b1, 1'b0, 4'(s));
    end
    push(8'h00, 1'b1, 1'b0, 4'd14);
    if (finish) begin
      push(8'h00, 1'b0, 1'b1, 4'd0);
      push(8'h00, 1'b0, 1'b0, 4'd0);
    end
  endtask

  // Advance n cycles, popping and comparing one expected entry per cycle.
  task automatic run_q(input int n, input bit rand_sw);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      play = 1'b0;
      stop = 1'b0;
      if (exp_q.size() == 0) begin
        check_eq("queue_empty", 32'(i), 32'(n));
        return;
      end
      e = exp_q.pop_front();
      check_eq($sformatf("note@%0d", i), 32'(note_sel), 32'(e.note));
      check_eq($sformatf("busy@%0d", i), 32'(busy), 32'(e.busy));
      check_eq($sformatf("done@%0d", i), 32'(done), 32'(e.done));
      check_eq($sformatf("step@%0d", i), 32'(step), 32'(e.step));
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (rand_sw) sw = 8'($urandom);
    end
  endtask

  initial begin
    RESET = 1'b1;
    play  = 1'b0;
    stop  = 1'b0;
    loop  = 1'b0;
    sw    = 8'h00;
    repeat (2) @(posedge CLK);
    #1;

    // Reset state
    push(8'h00, 1'b0, 1'b0, 4'd0);
    run_q(1, 1'b0);
    RESET = 1'b0;

    // Manual path: priority arbitration, one-cycle latency
    sw = 8'b0010_0100;
    push(8'h20, 1'b0, 1'b0, 4'd0);
    run_q(1, 1'b0);
    sw = 8'h00;
    push(8'h00, 1'b0, 1'b0, 4'd0);
    run_q(1, 1'b0);

    // Full song, no loop
    busy_cnt = 0;
    done_cnt = 0;
    play = 1'b1;
    push_song(1'b1);
    run_q(exp_q.size(), 1'b0);
    check_eq("busy_len", 32'(busy_cnt), 32'd199);
    check_eq("done_len", 32'(done_cnt), 32'd1);

    // Looping song, then stop
    busy_cnt = 0;
    done_cnt = 0;
    loop = 1'b1;
    play = 1'b1;
    push_song(1'b0);
    push(8'h00, 1'b1, 1'b0, 4'd0);
    for (int k = 0; k < 4; k++) push(8'h80, 1'b1, 1'b0, 4'd0);
    run_q(exp_q.size(), 1'b0);
    stop = 1'b1;
    push(8'h00, 1'b0, 1'b0, 4'd0);
    run_q(1, 1'b0);
    check_eq("loop_done", 32'(done_cnt), 32'd0);
    loop = 1'b0;

    // Stop at cycle 5 of note 2, then play+stop together in IDLE
    play = 1'b1;
    push_song(1'b1);
    run_q(32, 1'b0);
    exp_q.delete();
    stop = 1'b1;
    push(8'h00, 1'b0, 1'b0, 4'd0);
    run_q(1, 1'b0);
    play = 1'b1;
    stop = 1'b1;
    sw   = 8'h03;
    push(8'h02, 1'b0, 1'b0, 4'd0);
    push(8'h02, 1'b0, 1'b0, 4'd0);
    run_q(2, 1'b0);
    sw = 8'h00;
    push(8'h00, 1'b0, 1'b0, 4'd0);
    run_q(1, 1'b0);

    // Switches ignored during playback, then reset mid-note
    play = 1'b1;
    push_song(1'b1);
    run_q(20, 1'b1);
    exp_q.delete();
    sw    = 8'hFF;
    RESET = 1'b1;
    push(8'h00, 1'b0, 1'b0, 4'd0);
    run_q(1, 1'b0);
    RESET = 1'b0;
    push(8'h80, 1'b0, 1'b0, 4'd0);
    run_q(1, 1'b0);
    sw = 8'h00;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
